// File: rtl/range_finder_multi.sv
// Streaming min/max tracker that reports range, max, min or midpoint of a go..finish window.
// Optional saturating sample counter enabled by defining RANGE_FINDER_COUNT_EN.
module range_finder_multi #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             go,
    input  logic             finish,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic             debug_error
`ifdef RANGE_FINDER_COUNT_EN
    ,
    output logic [CNT_W-1:0] sample_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_ERROR = 2'd2
    } state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] min_reg;
    logic [WIDTH-1:0] max_reg;
    logic [1:0]       mode_reg;
    logic             pending_reg;

    logic             start_ok;
    logic [WIDTH-1:0] run_min;
    logic [WIDTH-1:0] run_max;
    logic [WIDTH:0]   mid_sum;
    logic [WIDTH-1:0] stat;

    generate
        if (WIDTH < 2 || CNT_W < 1) begin : g_param_check
            $error("range_finder_multi: WIDTH must be >= 2 and CNT_W >= 1");
        end
    endgenerate

    always_comb begin
        start_ok = go & ~finish;
        run_min  = (data_in < min_reg) ? data_in : min_reg;
        run_max  = (data_in > max_reg) ? data_in : max_reg;
        // Extra carry bit keeps the midpoint exact even when both ends are all-ones.
        mid_sum  = {1'b0, max_reg} + {1'b0, min_reg};
        stat     = '0;
        case (mode_reg)
            2'b00:   stat = max_reg - min_reg;
            2'b01:   stat = max_reg;
            2'b10:   stat = min_reg;
            default: stat = mid_sum[WIDTH:1];
        endcase
    end

    // Result is computed one edge after the finishing sample, from the final min/max.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= S_IDLE;
            min_reg      <= '0;
            max_reg      <= '0;
            mode_reg     <= 2'b00;
            pending_reg  <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            debug_error  <= 1'b0;
        end else begin
            result_valid <= pending_reg;
            pending_reg  <= 1'b0;
            if (pending_reg) begin
                result <= stat;
            end
            case (state_reg)
                S_IDLE, S_ERROR: begin
                    if (start_ok) begin
                        state_reg   <= S_RUN;
                        min_reg     <= data_in;
                        max_reg     <= data_in;
                        mode_reg    <= mode;
                        busy        <= 1'b1;
                        debug_error <= 1'b0;
                    end else if (finish) begin
                        state_reg   <= S_ERROR;
                        debug_error <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (go) begin
                        state_reg   <= S_ERROR;
                        busy        <= 1'b0;
                        debug_error <= 1'b1;
                    end else begin
                        min_reg <= run_min;
                        max_reg <= run_max;
                        if (finish) begin
                            state_reg   <= S_IDLE;
                            busy        <= 1'b0;
                            pending_reg <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

`ifdef RANGE_FINDER_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count_reg;

    // Counter saturates; the published count moves together with result_valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg    <= '0;
            sample_count <= '0;
        end else begin
            if (state_reg != S_RUN && start_ok) begin
                count_reg <= CNT_W'(1);
            end else if (state_reg == S_RUN && !go && count_reg != CNT_MAX) begin
                count_reg <= count_reg + 1'b1;
            end
            if (pending_reg) begin
                sample_count <= count_reg;
            end
        end
    end
`endif

endmodule
